// File: rtl/fifo_pkg.sv
// Purpose: shared Gray/binary helpers and synchronizer limits for the async FIFO.
// Latency: n/a (combinational functions and constants only).
// Backpressure: n/a.
// The conversion functions work on a fixed 32-bit container. Callers zero-extend
// a PTR_W-wide value in and truncate the result back to PTR_W. Zero upper bits do
// not change the XOR prefix, so any PTR_W up to 32 converts exactly.
package fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CONV_W          = 32;

  // Binary bit i is the XOR of Gray bits MSB..i, built from the top down.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
    logic [CONV_W-1:0] bin;
    bin[CONV_W-1] = gray[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Purpose: plain multi-flop synchronizer; usable for Gray buses or single-bit CDC.
// Latency: STAGES i_clk edges from i_d to o_q.
// Backpressure: none; samples every cycle.
// Ports: i_clk/i_rst (async, active-high) destination clock/reset; i_d foreign-domain
//        data; o_q value from the last stage.
// Nothing sits between stages so every flop gets the full period to resolve.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int k = 1; k < STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/sync_gray_ptr.sv
// Purpose: bring a foreign-domain Gray FIFO pointer into i_clk. Publish it as Gray and
//          as binary, with the per-cycle advance, and flag impossible jumps.
// Latency: Gray out after SYNC_STAGES edges; binary/advance after SYNC_STAGES+1 edges.
// Backpressure: none; outputs update every cycle.
// Ports: i_clk, i_rst (async, active-high); i_ptrGray foreign Gray pointer;
//        i_errClr clears the sticky error; o_syncPtrGray, o_syncPtrBin, o_advance,
//        o_ptrChanged (advance nonzero), o_overrunErr (sticky, advance > depth).
module sync_gray_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W:0]   i_ptrGray,
  input  logic              i_errClr,
  output logic [ADDR_W:0]   o_syncPtrGray,
  output logic [ADDR_W:0]   o_syncPtrBin,
  output logic [ADDR_W:0]   o_advance,
  output logic              o_ptrChanged,
  output logic              o_overrunErr
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(1) << ADDR_W;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_gray_ptr: SYNC_STAGES must be within 2..4");
  end

  logic [PTR_W-1:0] w_syncGray;
  logic [PTR_W-1:0] w_gb;
  logic [PTR_W-1:0] w_adv;
  logic             w_overrun;

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_adv;
  logic             r_changed;
  logic             r_err;

  sync_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_ptrGray),
    .o_q   (w_syncGray)
  );

  assign w_gb = PTR_W'(gray2bin(CONV_W'(w_syncGray)));
  // Modular subtraction: the wrap from max to 0 shows up as a step of 1.
  assign w_adv     = w_gb - r_bin;
  // A real pointer cannot move more than a full FIFO between samples.
  assign w_overrun = (w_adv > DEPTH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin     <= '0;
      r_adv     <= '0;
      r_changed <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_bin     <= w_gb;
      r_adv     <= w_adv;
      r_changed <= (w_adv != '0);
      // A set on the same edge as a clear wins, so no overrun is lost.
      if (w_overrun) begin
        r_err <= 1'b1;
      end else if (i_errClr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_syncPtrGray = w_syncGray;
  assign o_syncPtrBin  = r_bin;
  assign o_advance     = r_adv;
  assign o_ptrChanged  = r_changed;
  assign o_overrunErr  = r_err;

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Purpose: self-checking bench for sync_gray_ptr (SYNC_STAGES=2 and 3 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_gray_ptr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ptr = '0;
  logic       clr = 1'b0;

  logic [4:0] sg2, sb2, adv2, sg3, sb3, adv3;
  logic       chg2, err2, chg3, err3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_gray_ptr #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_ptrGray(ptr), .i_errClr(clr),
    .o_syncPtrGray(sg2), .o_syncPtrBin(sb2), .o_advance(adv2),
    .o_ptrChanged(chg2), .o_overrunErr(err2)
  );

  sync_gray_ptr #(.ADDR_W(4), .SYNC_STAGES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_ptrGray(ptr), .i_errClr(clr),
    .o_syncPtrGray(sg3), .o_syncPtrBin(sb3), .o_advance(adv3),
    .o_ptrChanged(chg3), .o_overrunErr(err3)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Gray code inverse found by search: the binary value whose Gray image matches.
  function automatic int g2b(input int g);
    for (int b = 0; b < 32; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic logic [4:0] b2g(input int b);
    int g;
    g = (b ^ (b >> 1)) & 31;
    return g[4:0];
  endfunction

  // Model: hist[0] is the pointer captured at the most recent edge.
  int hist [8];
  bit m_err2, m_err3;

  function automatic int m_sg(input int ss);
    return hist[ss-1];
  endfunction
  function automatic int m_bin(input int ss);
    return g2b(hist[ss]);
  endfunction
  function automatic int m_adv(input int ss);
    return (g2b(hist[ss]) - g2b(hist[ss+1])) & 31;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) hist[i] = 0;
      m_err2 = 1'b0;
      m_err3 = 1'b0;
    end else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(ptr);
      if (m_adv(2) > 16) m_err2 = 1'b1; else if (clr) m_err2 = 1'b0;
      if (m_adv(3) > 16) m_err3 = 1'b1; else if (clr) m_err3 = 1'b0;
    end
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_sg2", int'(sg2), 0);   chk("rst_sb2", int'(sb2), 0);
      chk("rst_adv2", int'(adv2), 0); chk("rst_chg2", int'(chg2), 0);
      chk("rst_err2", int'(err2), 0); chk("rst_sg3", int'(sg3), 0);
      chk("rst_adv3", int'(adv3), 0); chk("rst_err3", int'(err3), 0);
    end else begin
      chk("m_sg2", int'(sg2), m_sg(2));
      chk("m_sb2", int'(sb2), m_bin(2));
      chk("m_adv2", int'(adv2), m_adv(2));
      chk("m_chg2", int'(chg2), int'(m_adv(2) != 0));
      chk("m_err2", int'(err2), int'(m_err2));
      chk("m_sg3", int'(sg3), m_sg(3));
      chk("m_sb3", int'(sb3), m_bin(3));
      chk("m_adv3", int'(adv3), m_adv(3));
      chk("m_chg3", int'(chg3), int'(m_adv(3) != 0));
      chk("m_err3", int'(err3), int'(m_err3));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cur;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_sb", int'(sb2), 0);
    chk("reset_chg", int'(chg2), 0);

    // Single step 0 -> 1.
    ptr = 5'b00001;
    tick(2);
    chk("step_sg2", int'(sg2), 1);
    chk("step_sg3_lag", int'(sg3), 0);
    tick(1);
    chk("step_sb2", int'(sb2), 1);
    chk("step_adv2", int'(adv2), 1);
    chk("step_chg2", int'(chg2), 1);
    chk("step_sg3", int'(sg3), 1);
    tick(1);
    chk("step_adv2_idle", int'(adv2), 0);
    chk("step_adv3", int'(adv3), 1);

    // Walk one count per cycle up to 31, then wrap to 0.
    for (int k = 2; k < 32; k++) begin
      ptr = b2g(k);
      tick(1);
    end
    chk("gray31_literal", int'(ptr), 16);
    tick(5);
    ptr = 5'b00000;
    tick(3);
    chk("wrap_sb", int'(sb2), 0);
    chk("wrap_adv", int'(adv2), 1);
    chk("wrap_err", int'(err2), 0);
    tick(4);

    // Fast-source jump 3 -> 10.
    for (int k = 1; k < 4; k++) begin
      ptr = b2g(k);
      tick(1);
    end
    tick(4);
    ptr = 5'b01111;
    tick(3);
    chk("jump_adv", int'(adv2), 7);
    chk("jump_chg", int'(chg2), 1);
    chk("jump_err", int'(err2), 0);
    tick(1);

    // Asynchronous reset mid-traffic, outputs drop before the next edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sg", int'(sg2), 0);
    chk("arst_sb", int'(sb2), 0);
    chk("arst_adv", int'(adv2), 0);
    chk("arst_sg3", int'(sg3), 0);
    ptr = 5'b00000;
    tick(3);
    rst = 1'b0;
    tick(4);
    chk("post_rst_chg", int'(chg2), 0);

    // Overrun 0 -> 20.
    ptr = 5'b11110;
    tick(3);
    chk("ovr_adv", int'(adv2), 20);
    chk("ovr_err", int'(err2), 1);
    tick(3);
    chk("ovr_hold", int'(err2), 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("ovr_clr", int'(err2), 0);

    // New overrun 20 -> 5 (advance 17) with clear on the same edge.
    ptr = b2g(5);
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("ovr2_adv", int'(adv2), 17);
    chk("ovr2_set_wins", int'(err2), 1);
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("ovr2_clr", int'(err2), 0);
    chk("ovr2_clr3", int'(err3), 0);
    tick(3);

    // Pseudo-random traffic, occasional large jumps and clears.
    cur = 5;
    for (int i = 0; i < 60; i++) begin
      cur = (cur + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                                 : $urandom_range(0, 3))) & 31;
      ptr = b2g(cur);
      clr = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    clr = 1'b0;
    tick(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
